// File: rtl/oneton_mbit_demux_pkg.sv
// Shared constants and helpers for the 1-to-N M-bit stream demultiplexer.
package oneton_demux_pkg;

   // Default width of the saturating illegal-select drop counter.
   localparam int DEFAULT_CNT_W = 16;

   // Width of the destination select field; never narrower than one bit,
   // so even a degenerate channel count still has a real select wire.
   function automatic int sel_w(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage : oneton_demux_pkg

// File: rtl/oneton_mbit_demux_if.sv
// Bus bundle for the 1-to-N demultiplexer: one shared input stream, N
// independent output channels packed flat, plus illegal-select status.
//
// Handshake semantics (all streams in this bundle):
//   A beat transfers on a rising edge where valid && ready are both high.
//   valid never depends on ready; once raised it stays high with stable
//   data until the transfer. in_ready is combinational from in_sel and
//   out_ready (a deliberate out_ready -> in_ready timing path) and does not
//   depend on in_valid. Output channel i uses out_valid[i]/out_ready[i]
//   with data at out_data[(i+1)*M-1 : i*M].
interface oneton_mbit_demux_if
   import oneton_demux_pkg::*;
#(
   parameter int N     = 16,
   parameter int M     = 32,
   parameter int CNT_W = DEFAULT_CNT_W
);

   localparam int SEL_W = sel_w(N);

   logic             in_valid;
   logic             in_ready;
   logic [M-1:0]     in_data;
   logic [SEL_W-1:0] in_sel;
   logic [N-1:0]     out_valid;
   logic [N-1:0]     out_ready;
   logic [N*M-1:0]   out_data;
   logic             err_sel;
   logic [CNT_W-1:0] drop_cnt;

   // Producer plus consumers: drives the input beat and per-channel ready.
   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, err_sel, drop_cnt
   );

   // The demultiplexer itself.
   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, err_sel, drop_cnt
   );

endinterface : oneton_mbit_demux_if

// File: rtl/oneton_mbit_demux_chan_slot.sv
// One-entry holding register for a single output channel. A push and a
// pop on the same edge keep the slot full with the new data, which lets a
// channel sustain one beat per cycle while its consumer stays ready.
module demux_chan_slot #(
   parameter int M = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [M-1:0] push_data,
   input  logic         pop_ready,
   output logic         valid,
   output logic [M-1:0] data,
   output logic         can_accept
);

   logic         valid_q;
   logic         valid_d;
   logic [M-1:0] data_q;
   logic [M-1:0] data_d;
   logic         pop;

   // Next-state for occupancy and payload from the push/pop pair.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      pop     = valid_q && pop_ready;
      if (push) begin
         // Covers push-only and push-with-pop: slot ends up full either way.
         valid_d = 1'b1;
         data_d  = push_data;
      end else if (pop) begin
         // Payload is left in place; consumers ignore it while valid is low.
         valid_d = 1'b0;
      end
   end

   // Slot state; reset discards any held beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid      = valid_q;
   assign data       = data_q;
   // Room for a new beat this cycle: empty, or the held beat leaves now.
   assign can_accept = !valid_q || pop_ready;

endmodule : demux_chan_slot

// File: rtl/oneton_mbit_demux.sv
// Registered 1-to-N M-bit stream demultiplexer. Each accepted beat is
// steered by in_sel into that channel's one-entry slot; a full channel
// only stalls beats aimed at it. Selects at or above N are drained
// immediately, flagged on err_sel for one cycle and counted in drop_cnt.
module oneton_mbit_demux
   import oneton_demux_pkg::*;
#(
   parameter int N     = 16,
   parameter int M     = 32,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input logic                clk,
   input logic                rst_n,
   oneton_mbit_demux_if.slave bus
);

   localparam int               SEL_W = sel_w(N);
   // Channel count widened by one bit so the legality compare works even
   // when N is an exact power of two.
   localparam logic [SEL_W:0]   N_LIM = (SEL_W + 1)'(N);

   logic             sel_ok;
   logic             ready_sel;
   logic             in_ready_c;
   logic             accept;
   logic [N-1:0]     push_vec;
   logic [N-1:0]     can_accept;
   logic [N-1:0]     slot_valid;
   logic [M-1:0]     slot_data [N];
   logic [N*M-1:0]   out_data_c;

   logic             err_sel_q;
   logic             err_sel_d;
   logic [CNT_W-1:0] drop_cnt_q;
   logic [CNT_W-1:0] drop_cnt_d;

   // Select legality: anything at or beyond N has no slot behind it.
   always_comb begin
      sel_ok = ({1'b0, bus.in_sel} < N_LIM);
   end

   // Input ready: the selected slot's room, or always ready for an illegal
   // select so bad beats drain. Held low while reset is asserted.
   always_comb begin
      ready_sel = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (bus.in_sel == SEL_W'(i)) begin
            ready_sel = can_accept[i];
         end
      end
      in_ready_c = rst_n && ready_sel;
   end

   // Accept decode and one-hot push to the addressed slot.
   always_comb begin
      accept = bus.in_valid && in_ready_c;
      for (int i = 0; i < N; i++) begin
         push_vec[i] = accept && sel_ok && (bus.in_sel == SEL_W'(i));
      end
   end

   // Error pulse and saturating drop count for illegal-select beats.
   always_comb begin
      err_sel_d  = accept && !sel_ok;
      drop_cnt_d = drop_cnt_q;
      if (err_sel_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   // Status registers; both clear immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sel_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         err_sel_q  <= err_sel_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // One holding slot per output channel.
   for (genvar g = 0; g < N; g++) begin : g_slot
      demux_chan_slot #(
         .M (M)
      ) u_slot (
         .clk        (clk),
         .rst_n      (rst_n),
         .push       (push_vec[g]),
         .push_data  (bus.in_data),
         .pop_ready  (bus.out_ready[g]),
         .valid      (slot_valid[g]),
         .data       (slot_data[g]),
         .can_accept (can_accept[g])
      );
   end

   // Pack slot payloads into the flat bus, channel i in slice i.
   always_comb begin
      out_data_c = '0;
      for (int i = 0; i < N; i++) begin
         out_data_c[i*M +: M] = slot_data[i];
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = slot_valid;
   assign bus.out_data  = out_data_c;
   assign bus.err_sel   = err_sel_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule : oneton_mbit_demux

// File: tb/tb_oneton_mbit_demux.sv
// Bench for the 1-to-N demultiplexer: a 16-channel instance (A) and a
// 5-channel, 2-bit-counter instance (B) share clock and reset. A model of
// N capacity-one channel queues supplies every expected value.
module tb_oneton_mbit_demux;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   oneton_mbit_demux_if #(.N(16), .M(32), .CNT_W(16)) bus_a ();
   oneton_mbit_demux_if #(.N(5),  .M(32), .CNT_W(2))  bus_b ();

   oneton_mbit_demux #(.N(16), .M(32), .CNT_W(16)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   oneton_mbit_demux #(.N(5), .M(32), .CNT_W(2)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int          n_of [2] = '{16, 5};
   int          cmax [2] = '{65535, 3};
   logic [31:0] mq [2][16][$];
   int          drop_m [2];
   bit          err_m  [2];

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) mq[k][i].delete();
         drop_m[k] = 0;
         err_m[k]  = 1'b0;
      end
   endtask

   function automatic bit m_ready(int k, int sel, logic [15:0] ordy);
      if (sel >= n_of[k]) return 1'b1;
      return (mq[k][sel].size() == 0) || ordy[sel];
   endfunction

   function automatic logic [15:0] m_valid(int k);
      logic [15:0] v = '0;
      for (int i = 0; i < n_of[k]; i++) v[i] = (mq[k][i].size() != 0);
      return v;
   endfunction

   task automatic m_edge(int k, bit vld, int sel, logic [31:0] d, logic [15:0] ordy);
      bit acc;
      acc = vld && m_ready(k, sel, ordy);
      for (int i = 0; i < n_of[k]; i++)
         if (mq[k][i].size() != 0 && ordy[i]) void'(mq[k][i].pop_front());
      if (acc && sel < n_of[k]) mq[k][sel].push_back(d);
      err_m[k] = acc && (sel >= n_of[k]);
      if (err_m[k] && drop_m[k] < cmax[k]) drop_m[k]++;
   endtask

   // Advance model by one edge with the inputs currently driven, then move
   // to the next falling edge.
   task automatic tick();
      if (rst_n) begin
         m_edge(0, bus_a.in_valid, int'(bus_a.in_sel), bus_a.in_data, bus_a.out_ready);
         m_edge(1, bus_b.in_valid, int'(bus_b.in_sel), bus_b.in_data, {11'b0, bus_b.out_ready});
      end
      @(negedge clk);
   endtask

   task automatic idle_all();
      bus_a.in_valid = 1'b0; bus_a.in_sel = '0; bus_a.in_data = '0; bus_a.out_ready = '0;
      bus_b.in_valid = 1'b0; bus_b.in_sel = '0; bus_b.in_data = '0; bus_b.out_ready = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d3, d9, d;
      rst_n = 1'b0;
      idle_all();
      m_reset();
      bus_a.in_valid = 1'b1;
      bus_a.in_sel   = 4'd3;
      repeat (2) @(negedge clk);
      #1;
      n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", bus_a.in_ready); end
      n_tests++; if (bus_a.out_valid !== 16'h0) begin n_fail++; $display("FAIL rst_out_valid: got %h exp 0", bus_a.out_valid); end
      n_tests++; if (bus_a.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got nonzero exp 0"); end
      n_tests++; if (bus_a.drop_cnt !== 16'd0 || bus_a.err_sel !== 1'b0) begin n_fail++; $display("FAIL rst_status: drop %h err %b exp 0 0", bus_a.drop_cnt, bus_a.err_sel); end
      n_tests++; if (bus_b.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_b: got %b exp 0", bus_b.in_ready); end

      @(negedge clk);
      rst_n = 1'b1;
      d3 = $urandom; d9 = $urandom;
      bus_a.in_sel = 4'd3; bus_a.in_data = d3;
      #1;
      n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %b exp 1", bus_a.in_ready); end
      tick();
      bus_a.in_sel = 4'd9; bus_a.in_data = d9;
      tick();
      bus_a.in_valid = 1'b0;
      #1;
      n_tests++; if (bus_a.out_valid !== 16'h0208) begin n_fail++; $display("FAIL fill_valid: got %h exp 0208", bus_a.out_valid); end
      n_tests++; if (bus_a.out_data[3*32 +: 32] !== d3 || bus_a.out_data[9*32 +: 32] !== d9) begin n_fail++; $display("FAIL fill_data: got %h %h exp %h %h", bus_a.out_data[3*32 +: 32], bus_a.out_data[9*32 +: 32], d3, d9); end

      // Assert reset between edges: effect must be immediate.
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      n_tests++; if (bus_a.out_valid !== 16'h0) begin n_fail++; $display("FAIL async_rst_valid: got %h exp 0", bus_a.out_valid); end
      n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b exp 0", bus_a.in_ready); end
      n_tests++; if (bus_a.out_data !== '0 || bus_a.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst_data: drop %h exp 0", bus_a.drop_cnt); end

      @(negedge clk);
      rst_n = 1'b1;
      d = $urandom;
      bus_a.in_valid = 1'b1; bus_a.in_sel = 4'd3; bus_a.in_data = d;
      #1;
      n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b exp 1", bus_a.in_ready); end
      tick();
      bus_a.in_valid = 1'b0;
      #1;
      n_tests++; if (bus_a.out_valid !== 16'h0008 || bus_a.out_data[3*32 +: 32] !== d) begin n_fail++; $display("FAIL post_rst_beat: valid %h data %h exp 0008 %h", bus_a.out_valid, bus_a.out_data[3*32 +: 32], d); end
      tick();
   endtask

   task automatic test_streaming();
      bus_a.out_ready = '1;
      for (int i = 0; i < 256; i++) begin
         bus_a.in_valid = 1'b1; bus_a.in_sel = 4'd5; bus_a.in_data = 32'(i);
         #1;
         n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b exp 1", i, bus_a.in_ready); end
         if (i > 0) begin
            n_tests++; if (bus_a.out_valid[5] !== 1'b1 || bus_a.out_data[5*32 +: 32] !== 32'(i - 1)) begin n_fail++; $display("FAIL stream_data[%0d]: valid %b data %h exp 1 %h", i, bus_a.out_valid[5], bus_a.out_data[5*32 +: 32], i - 1); end
         end
         tick();
      end
      bus_a.in_valid = 1'b0;
      #1;
      n_tests++; if (bus_a.out_valid[5] !== 1'b1 || bus_a.out_data[5*32 +: 32] !== 32'd255) begin n_fail++; $display("FAIL stream_last: valid %b data %h exp 1 ff", bus_a.out_valid[5], bus_a.out_data[5*32 +: 32]); end
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] va, vb, vc;
      va = $urandom; vb = $urandom; vc = $urandom;
      bus_a.out_ready = ~16'h0080;
      bus_a.in_valid = 1'b0;
      tick();
      bus_a.in_valid = 1'b1; bus_a.in_sel = 4'd7; bus_a.in_data = va;
      #1;
      n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_a_ready: got %b exp 1", bus_a.in_ready); end
      tick();
      for (int r = 0; r < 3; r++) begin
         bus_a.in_sel = 4'd7; bus_a.in_data = vb;
         #1;
         n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_b_stall[%0d]: got %b exp 0", r, bus_a.in_ready); end
         n_tests++; if (bus_a.out_valid[7] !== 1'b1 || bus_a.out_data[255:224] !== va) begin n_fail++; $display("FAIL bp_a_hold[%0d]: valid %b data %h exp 1 %h", r, bus_a.out_valid[7], bus_a.out_data[255:224], va); end
         tick();
      end
      bus_a.in_sel = 4'd2; bus_a.in_data = vc;
      #1;
      n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_c_ready: got %b exp 1", bus_a.in_ready); end
      tick();
      bus_a.in_sel = 4'd7; bus_a.in_data = vb;
      #1;
      n_tests++; if (bus_a.out_valid[2] !== 1'b1 || bus_a.out_data[2*32 +: 32] !== vc) begin n_fail++; $display("FAIL bp_c_out: valid %b data %h exp 1 %h", bus_a.out_valid[2], bus_a.out_data[2*32 +: 32], vc); end
      n_tests++; if (bus_a.in_ready !== 1'b0 || bus_a.out_data[255:224] !== va) begin n_fail++; $display("FAIL bp_still_held: ready %b data %h exp 0 %h", bus_a.in_ready, bus_a.out_data[255:224], va); end
      tick();
      bus_a.out_ready[7] = 1'b1;
      #1;
      n_tests++; if (bus_a.in_ready !== 1'b1 || bus_a.out_data[255:224] !== va) begin n_fail++; $display("FAIL bp_release: ready %b data %h exp 1 %h", bus_a.in_ready, bus_a.out_data[255:224], va); end
      tick();
      bus_a.in_valid = 1'b0;
      #1;
      n_tests++; if (bus_a.out_valid[7] !== 1'b1 || bus_a.out_data[255:224] !== vb) begin n_fail++; $display("FAIL bp_b_out: valid %b data %h exp 1 %h", bus_a.out_valid[7], bus_a.out_data[255:224], vb); end
      bus_a.out_ready = '1;
      tick();
   endtask

   task automatic test_push_pop();
      bus_a.out_ready = ~16'h0001;
      bus_a.in_valid = 1'b1; bus_a.in_sel = 4'd0; bus_a.in_data = 32'hDEAD_BEEF;
      tick();
      bus_a.in_valid = 1'b0;
      #1;
      n_tests++; if (bus_a.out_valid[0] !== 1'b1 || bus_a.out_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pp_hold: valid %b data %h exp 1 deadbeef", bus_a.out_valid[0], bus_a.out_data[31:0]); end
      tick();
      bus_a.out_ready[0] = 1'b1;
      bus_a.in_valid = 1'b1; bus_a.in_sel = 4'd0; bus_a.in_data = 32'h1234_5678;
      #1;
      n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready: got %b exp 1", bus_a.in_ready); end
      tick();
      bus_a.in_valid = 1'b0;
      bus_a.out_ready[0] = 1'b0;
      #1;
      n_tests++; if (bus_a.out_valid[0] !== 1'b1 || bus_a.out_data[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL pp_replace: valid %b data %h exp 1 12345678", bus_a.out_valid[0], bus_a.out_data[31:0]); end
      bus_a.out_ready = '1;
      tick();
   endtask

   task automatic test_illegal();
      logic [31:0] x;
      int          err_seen;
      int          exp_drop;
      x = $urandom;
      err_seen = 0;
      bus_b.out_ready = '0;
      bus_b.in_valid = 1'b1; bus_b.in_sel = 3'd1; bus_b.in_data = x;
      tick();
      for (int k = 0; k < 5; k++) begin
         bus_b.in_valid = 1'b1; bus_b.in_sel = 3'd6; bus_b.in_data = $urandom;
         #1;
         n_tests++; if (bus_b.in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready[%0d]: got %b exp 1", k, bus_b.in_ready); end
         if (bus_b.err_sel === 1'b1) err_seen++;
         if (k > 0) begin
            exp_drop = (k > 3) ? 3 : k;
            n_tests++; if (bus_b.err_sel !== 1'b1 || bus_b.drop_cnt !== 2'(exp_drop)) begin n_fail++; $display("FAIL ill_cnt[%0d]: err %b drop %0d exp 1 %0d", k, bus_b.err_sel, bus_b.drop_cnt, exp_drop); end
         end
         n_tests++; if (bus_b.out_valid !== 5'b00010 || bus_b.out_data[63:32] !== x) begin n_fail++; $display("FAIL ill_slots[%0d]: valid %b data %h exp 00010 %h", k, bus_b.out_valid, bus_b.out_data[63:32], x); end
         tick();
      end
      bus_b.in_valid = 1'b0;
      #1;
      if (bus_b.err_sel === 1'b1) err_seen++;
      n_tests++; if (bus_b.err_sel !== 1'b1 || bus_b.drop_cnt !== 2'd3) begin n_fail++; $display("FAIL ill_last: err %b drop %0d exp 1 3", bus_b.err_sel, bus_b.drop_cnt); end
      tick();
      #1;
      if (bus_b.err_sel === 1'b1) err_seen++;
      n_tests++; if (bus_b.err_sel !== 1'b0 || bus_b.drop_cnt !== 2'd3) begin n_fail++; $display("FAIL ill_idle: err %b drop %0d exp 0 3", bus_b.err_sel, bus_b.drop_cnt); end
      n_tests++; if (err_seen != 5) begin n_fail++; $display("FAIL ill_pulses: got %0d exp 5", err_seen); end
      n_tests++; if (bus_b.out_valid !== 5'b00010 || bus_b.out_data[63:32] !== x) begin n_fail++; $display("FAIL ill_slot_final: valid %b data %h exp 00010 %h", bus_b.out_valid, bus_b.out_data[63:32], x); end
      bus_b.out_ready = '1;
      tick();
   endtask

   task automatic test_random();
      int          thr;
      logic [15:0] ev;
      logic [4:0]  evb;
      bit          er;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         thr = (cyc / 250) % 4 + 1;
         bus_a.in_valid = ($urandom_range(0, 3) != 0);
         bus_a.in_sel   = 4'($urandom_range(0, 15));
         bus_a.in_data  = $urandom;
         for (int i = 0; i < 16; i++) bus_a.out_ready[i] = ($urandom_range(0, 3) < thr);
         bus_b.in_valid = ($urandom_range(0, 3) != 0);
         bus_b.in_sel   = 3'($urandom_range(0, 7));
         bus_b.in_data  = $urandom;
         for (int i = 0; i < 5; i++) bus_b.out_ready[i] = ($urandom_range(0, 3) < thr);
         #1;
         er = m_ready(0, int'(bus_a.in_sel), bus_a.out_ready);
         n_tests++; if (bus_a.in_ready !== er) begin n_fail++; $display("FAIL rnd_a_ready@%0d: got %b exp %b", cyc, bus_a.in_ready, er); end
         ev = m_valid(0);
         n_tests++; if (bus_a.out_valid !== ev) begin n_fail++; $display("FAIL rnd_a_valid@%0d: got %h exp %h", cyc, bus_a.out_valid, ev); end
         for (int i = 0; i < 16; i++) begin
            if (mq[0][i].size() != 0) begin
               n_tests++; if (bus_a.out_data[i*32 +: 32] !== mq[0][i][0]) begin n_fail++; $display("FAIL rnd_a_data@%0d ch%0d: got %h exp %h", cyc, i, bus_a.out_data[i*32 +: 32], mq[0][i][0]); end
            end
         end
         n_tests++; if (bus_a.err_sel !== err_m[0] || bus_a.drop_cnt !== 16'(drop_m[0])) begin n_fail++; $display("FAIL rnd_a_status@%0d: err %b drop %0d exp %b %0d", cyc, bus_a.err_sel, bus_a.drop_cnt, err_m[0], drop_m[0]); end

         er = m_ready(1, int'(bus_b.in_sel), {11'b0, bus_b.out_ready});
         n_tests++; if (bus_b.in_ready !== er) begin n_fail++; $display("FAIL rnd_b_ready@%0d: got %b exp %b", cyc, bus_b.in_ready, er); end
         ev  = m_valid(1);
         evb = ev[4:0];
         n_tests++; if (bus_b.out_valid !== evb) begin n_fail++; $display("FAIL rnd_b_valid@%0d: got %b exp %b", cyc, bus_b.out_valid, evb); end
         for (int i = 0; i < 5; i++) begin
            if (mq[1][i].size() != 0) begin
               n_tests++; if (bus_b.out_data[i*32 +: 32] !== mq[1][i][0]) begin n_fail++; $display("FAIL rnd_b_data@%0d ch%0d: got %h exp %h", cyc, i, bus_b.out_data[i*32 +: 32], mq[1][i][0]); end
            end
         end
         n_tests++; if (bus_b.err_sel !== err_m[1] || bus_b.drop_cnt !== 2'(drop_m[1])) begin n_fail++; $display("FAIL rnd_b_status@%0d: err %b drop %0d exp %b %0d", cyc, bus_b.err_sel, bus_b.drop_cnt, err_m[1], drop_m[1]); end
         tick();
      end
      idle_all();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_push_pop();
      test_illegal();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_oneton_mbit_demux

// File: doc/oneton_mbit_demux.md
Name: oneton_mbit_demux

Overview:
- Registered 1-to-N M-bit stream demultiplexer; the inverse of the team's N:1 M-bit mux.
- One valid/ready input stream carries a destination select per beat. Each beat is routed into a one-entry holding slot for the selected output channel.
- Sits between a shared producer (e.g. a response bus) and N independent consumers. Backpressure on one channel must not corrupt other channels.
- Flat packed output bus layout matches the N:1 mux input layout: channel i occupies bits [(i+1)*M-1 : i*M].

Parameters:
- N, 16, number of output channels (N >= 2; need not be a power of two).
- M, 32, data width per channel (M >= 1).
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset. Assert asynchronously; the integrator supplies synchronous deassertion.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  M  input beat data.
- in_sel  input  $clog2(N)  destination channel for this beat.
- out_valid  output  N  per-channel valid (bit i = channel i).
- out_ready  input  N  per-channel ready.
- out_data  output  N*M  flat channel data; channel i at [(i+1)*M-1 : i*M].
- err_sel  output  1  one-cycle pulse the cycle after an illegal-select beat is accepted.
- drop_cnt  output  CNT_W  count of illegal-select beats, saturating at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid = 0, all slot data = 0, err_sel = 0, drop_cnt = 0. Applies immediately, mid-transfer included.
  - Slot contents are discarded, not flushed.
  - in_ready = 0 while rst_n = 0.
- Legal select: sel_ok = (in_sel < N).
- in_ready is combinational:
  - sel_ok: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - !sel_ok: in_ready = 1, so illegal beats are drained and never stall the producer.
  - in_ready must not depend on in_valid.
  - The combinational out_ready -> in_ready path is intentional and documented for timing.
- Accept, legal select: the next edge loads slot[in_sel] with in_data and sets out_valid[in_sel] = 1. Latency is 1 cycle from accept to out_valid.
- Accept, illegal select:
  - Data is discarded; no slot changes.
  - err_sel = 1 for exactly the next cycle.
  - drop_cnt increments, holding at 2^CNT_W-1 once reached.
- Per-channel slot update each edge, with push = legal accept targeting i and pop = out_valid[i] && out_ready[i]:
  - push only: valid <= 1, data <= in_data.
  - pop only: valid <= 0; data is held (don't-care to consumers).
  - push and pop on the same edge: valid stays 1, data replaced. This gives full throughput of one beat per cycle per channel when out_ready stays high.
  - neither: hold.
- Protocol rules:
  - While out_valid[i] = 1 and out_ready[i] = 0, out_data for channel i is stable.
  - out_valid[i] never drops without a pop.
- Only one channel can be pushed per cycle. Pops on any number of channels happen in parallel.
- Channel independence: a stalled channel k blocks only beats with in_sel = k. Beats to other channels proceed in the same cycle.
- No reordering within a channel. Ordering across channels is not defined.
- N a power of two: sel_ok is always 1, and err_sel and drop_cnt stay 0.

Decomposition:
- Package oneton_demux_pkg: sel_w(N) constant function (returns $clog2(N), minimum 1) and the default CNT_W localparam.
- Sub-module demux_chan_slot (parameter M): one-entry register slot.
  - Ports: clk, rst_n, push, push_data, pop_ready, valid, data, can_accept (= !valid || pop_ready).
  - Top level instantiates N slots in a generate loop.
  - Top level also holds select decode, in_ready mux, err_sel flop and drop counter.

Test Plan:
- Reset mid-traffic: N=16, M=32, fill channels 3 and 9, assert rst_n=0 asynchronously between edges -> out_valid=0 immediately, drop_cnt=0, in_ready=0; after release, a beat to ch3 appears 1 cycle later.
- Streaming: out_ready=all ones, send in_data=0x0000_0000..0x0000_00FF, all with in_sel=5 -> out_valid[5] high every cycle from cycle 1, data in order, in_ready never low.
- Backpressure isolation: out_ready[7]=0, beats A to ch7, then B to ch7, then C to ch2 -> A held stable on [255:224], in_ready=0 while B is presented, C is accepted once presented and appears on ch2 next cycle. Raise out_ready[7] -> A pops, B is accepted in the same cycle.
- Simultaneous push/pop: ch0 holding 0xDEAD_BEEF with out_ready[0]=1, push 0x1234_5678 to ch0 -> out_valid[0] stays 1, next data = 0x1234_5678, no lost beat.
- Illegal select: N=5, CNT_W=2, send 5 beats with in_sel=6 -> in_ready=1 on each, err_sel pulses 5 times, drop_cnt=1,2,3,3,3, all slots unchanged.
- Random regression: N=5 and N=16, random valid/ready/sel with a scoreboard per channel -> per-channel order preserved, no data loss or duplication, stability assertion never fires.
